// File: rtl/button_plant_3x4_pkg.sv
// Shared sizes, key indexing and FSM state encoding for the 3x4 keypad emulator.
// Key index is row*3 + col for both the static level bitmap and injected codes.
package button_plant_3x4_pkg;

    localparam int KEY_NUM = 12;
    localparam int COL_NUM = 3;
    localparam int ROW_NUM = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/button_plant_3x4_col_sync.sv
// Column strobe synchronizer: resolves the active column and flags the end of
// each complete sweep (column 2 strobe released after a clean column-2 pattern).
module button_plant_3x4_col_sync
    import button_plant_3x4_pkg::*;
#(
    parameter int COL_SYNC_STAGES = 2
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [2:0] i_col_n,
    output logic       col_valid,
    output logic [1:0] col_idx,
    output logic       sweep_evt
);

    logic [2:0] col_s;
    logic [2:0] col_prev;

    generate
        if (COL_SYNC_STAGES == 0) begin : g_direct
            assign col_s = i_col_n;
        end else begin : g_sync
            logic [2:0] sync_q [COL_SYNC_STAGES];

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    for (int i = 0; i < COL_SYNC_STAGES; i++) begin
                        sync_q[i] <= 3'b111;
                    end
                end else begin
                    sync_q[0] <= i_col_n;
                    for (int i = 1; i < COL_SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign col_s = sync_q[COL_SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        col_valid = 1'b0;
        col_idx   = 2'd0;
        case (col_s)
            3'b110: begin col_valid = 1'b1; col_idx = 2'd0; end
            3'b101: begin col_valid = 1'b1; col_idx = 2'd1; end
            3'b011: begin col_valid = 1'b1; col_idx = 2'd2; end
            default: begin col_valid = 1'b0; col_idx = 2'd0; end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col_prev <= 3'b111;
        end else begin
            col_prev <= col_s;
        end
    end

    // Only a clean column-2 strobe ending counts; glitches through 000/111 never do.
    assign sweep_evt = (col_prev == 3'b011) && col_s[2];

endmodule

// File: rtl/button_plant_3x4_emulator.sv
// Virtual 3x4 keypad: answers the scanner's column strobes with row returns
// from a static level bitmap OR-ed with a timed injected key press.
//
// state | meaning
// IDLE  | ready for an injection request
// PRESS | injected key held down, counting HOLD_SCANS sweeps
// GAP   | injected key released, counting GAP_SCANS sweeps before next request
module button_plant_3x4_emulator
    import button_plant_3x4_pkg::*;
#(
    parameter int HOLD_SCANS      = 16,
    parameter int GAP_SCANS       = 8,
    parameter int COL_SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [2:0]  i_col_n,
    output logic [3:0]  o_row_n,
    input  logic        s_key_valid,
    output logic        s_key_ready,
    input  logic [3:0]  s_key_code,
    input  logic [11:0] i_key_level,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  code_q, code_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        ready_en_q;
    logic [3:0]  row_q, row_d;
    logic [11:0] inject_map;
    logic [11:0] press_map;
    logic        col_valid;
    logic [1:0]  col_idx;
    logic        sweep_evt;
    logic        accept;

    button_plant_3x4_col_sync #(
        .COL_SYNC_STAGES(COL_SYNC_STAGES)
    ) u_col_sync (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_col_n   (i_col_n),
        .col_valid (col_valid),
        .col_idx   (col_idx),
        .sweep_evt (sweep_evt)
    );

    // Held low through reset, so ready rises on the first clock after release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    assign s_key_ready = (state_q == IDLE) && ready_en_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign accept      = s_key_valid && s_key_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_key_code < 4'(KEY_NUM)) begin
                        code_d  = s_key_code;
                        cnt_d   = 8'd0;
                        state_d = PRESS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRESS: begin
                if (sweep_evt) begin
                    if (cnt_q + 8'd1 == 8'(HOLD_SCANS)) begin
                        cnt_d   = 8'd0;
                        state_d = GAP;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            GAP: begin
                if (sweep_evt) begin
                    if (cnt_q + 8'd1 == 8'(GAP_SCANS)) begin
                        cnt_d   = 8'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            code_q  <= 4'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign inject_map = (state_q == PRESS) ? (12'd1 << code_q) : 12'd0;
    assign press_map  = i_key_level | inject_map;

    always_comb begin
        row_d = 4'hF;
        if (col_valid) begin
            for (int r = 0; r < ROW_NUM; r++) begin
                row_d[r] = ~press_map[key_index(2'(r), col_idx)];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            row_q <= 4'hF;
        end else begin
            row_q <= row_d;
        end
    end

    assign o_row_n = row_q;

endmodule

// File: tb/tb_button_plant_3x4_emulator.sv
// Directed bench for the 3x4 keypad emulator: a scanner model drives column
// strobes, expected row returns are queued on drive and compared after settling.
module tb_button_plant_3x4_emulator;

    localparam int HOLD  = 3;
    localparam int GAPN  = 2;
    localparam int SYNC  = 2;
    localparam int DWELL = 5;

    logic        aclk;
    logic        aresetn;
    logic [2:0]  i_col_n;
    logic [3:0]  o_row_n;
    logic        s_key_valid;
    logic        s_key_ready;
    logic [3:0]  s_key_code;
    logic [11:0] i_key_level;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int err_pulses = 0;
    int done_ready_bad = 0;
    int exp_done = 0;

    int          model_state = 0;
    int          model_cnt = 0;
    logic [3:0]  model_code = 4'd0;
    logic [11:0] model_level = 12'd0;
    logic [2:0]  prev_col = 3'b111;

    logic [3:0] exp_q[$];
    string      tag_q[$];

    button_plant_3x4_emulator #(
        .HOLD_SCANS(HOLD),
        .GAP_SCANS(GAPN),
        .COL_SYNC_STAGES(SYNC)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_col_n     (i_col_n),
        .o_row_n     (o_row_n),
        .s_key_valid (s_key_valid),
        .s_key_ready (s_key_ready),
        .s_key_code  (s_key_code),
        .i_key_level (i_key_level),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (o_done) done_pulses++;
        if (o_err) err_pulses++;
        if (o_done && !s_key_ready) done_ready_bad++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_row(input logic [2:0] col, input logic [11:0] level,
                                             input logic press, input logic [3:0] code);
        int c;
        logic [11:0] m;
        logic [3:0] r;
        case (col)
            3'b110: c = 0;
            3'b101: c = 1;
            3'b011: c = 2;
            default: return 4'hF;
        endcase
        m = level;
        if (press) m[code] = 1'b1;
        for (int row = 0; row < 4; row++) r[row] = ~m[row*3 + c];
        return r;
    endfunction

    task automatic drive_col(input logic [2:0] col, input string tag);
        logic evt;
        string t;
        logic [3:0] e;
        evt = (prev_col == 3'b011) && col[2];
        if (evt && model_state != 0) begin
            model_cnt++;
            if (model_state == 1 && model_cnt == HOLD) begin
                model_state = 2;
                model_cnt = 0;
            end else if (model_state == 2 && model_cnt == GAPN) begin
                model_state = 0;
                model_cnt = 0;
                exp_done++;
            end
        end
        prev_col = col;
        i_col_n = col;
        exp_q.push_back(model_row(col, model_level, model_state == 1, model_code));
        tag_q.push_back(tag);
        repeat (DWELL) @(negedge aclk);
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check(t, 32'(o_row_n), 32'(e));
        check({t, "_busy"}, 32'(o_busy), 32'(model_state != 0));
    endtask

    task automatic sweep(input string tag);
        drive_col(3'b101, {tag, "_c1"});
        drive_col(3'b011, {tag, "_c2"});
        drive_col(3'b110, {tag, "_c0"});
    endtask

    task automatic inject(input logic [3:0] code, input string tag);
        logic bad;
        bad = (code >= 4'd12);
        check({tag, "_rdy_pre"}, 32'(s_key_ready), 32'd1);
        s_key_valid = 1'b1;
        s_key_code = code;
        @(negedge aclk);
        s_key_valid = 1'b0;
        if (!bad) begin
            model_state = 1;
            model_cnt = 0;
            model_code = code;
        end
        check({tag, "_busy_acc"}, 32'(o_busy), 32'(!bad));
        check({tag, "_rdy_acc"}, 32'(s_key_ready), 32'(bad));
        check({tag, "_err_acc"}, 32'(o_err), 32'(bad));
    endtask

    task automatic release_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        model_state = 0;
        model_cnt = 0;
        prev_col = i_col_n;
        repeat (3) @(negedge aclk);
    endtask

    initial begin
        logic [3:0] row_before;
        aresetn = 1'b0;
        i_col_n = 3'b110;
        i_key_level = 12'hFFF;
        s_key_valid = 1'b0;
        s_key_code = 4'd0;

        // reset with every key held
        repeat (3) @(negedge aclk);
        check("rst_row", 32'(o_row_n), 32'hF);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_rdy", 32'(s_key_ready), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        model_level = 12'hFFF;
        release_reset();
        check("post_rst_rdy", 32'(s_key_ready), 32'd1);
        check("post_rst_row_all", 32'(o_row_n), 32'h0);

        // static level: key 4 = row1, col1
        model_level = 12'h010;
        i_key_level = model_level;
        drive_col(3'b110, "st_c0");
        i_col_n = 3'b101;
        prev_col = 3'b101;
        repeat (SYNC) @(negedge aclk);
        check("st_lat_pre", 32'(o_row_n), 32'hF);
        @(negedge aclk);
        check("st_lat_post", 32'(o_row_n), 32'b1101);
        repeat (2) @(negedge aclk);
        drive_col(3'b011, "st_c2");
        drive_col(3'b110, "st_c0b");
        drive_col(3'b101, "st_c1b");
        drive_col(3'b110, "st_c0c");
        model_level = 12'h000;
        i_key_level = model_level;
        drive_col(3'b110, "st_clear");

        // timed injection of key 11 (row3, col2)
        inject(4'd11, "inj11");
        for (int i = 0; i < HOLD; i++) sweep($sformatf("inj11_p%0d", i));
        for (int i = 0; i < GAPN; i++) sweep($sformatf("inj11_g%0d", i));
        check("inj11_done", 32'(done_pulses), 32'(exp_done));
        check("inj11_rdy_end", 32'(s_key_ready), 32'd1);
        check("done_with_ready", 32'(done_ready_bad), 32'd0);

        // out-of-range code
        row_before = o_row_n;
        inject(4'd13, "bad13");
        @(negedge aclk);
        check("bad13_err_off", 32'(o_err), 32'd0);
        check("bad13_row", 32'(o_row_n), 32'(row_before));
        check("bad13_busy", 32'(o_busy), 32'd0);
        check("bad13_pulses", 32'(err_pulses), 32'd1);

        // malformed column patterns while key 0 held
        inject(4'd0, "inv0");
        drive_col(3'b110, "inv_c0");
        drive_col(3'b000, "inv_000");
        drive_col(3'b111, "inv_111");
        drive_col(3'b110, "inv_c0b");
        for (int i = 0; i < HOLD; i++) sweep($sformatf("inv_p%0d", i));
        for (int i = 0; i < GAPN; i++) sweep($sformatf("inv_g%0d", i));
        check("inv_done", 32'(done_pulses), 32'(exp_done));

        // reset in the middle of PRESS
        inject(4'd11, "mid");
        sweep("mid_p0");
        drive_col(3'b101, "mid_c1");
        drive_col(3'b011, "mid_c2");
        aresetn = 1'b0;
        #1;
        check("mid_rst_row", 32'(o_row_n), 32'hF);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        repeat (2) @(negedge aclk);
        release_reset();
        check("mid_rel_rdy", 32'(s_key_ready), 32'd1);
        drive_col(3'b110, "mid_park");
        inject(4'd11, "fresh");
        for (int i = 0; i < HOLD; i++) sweep($sformatf("fresh_p%0d", i));
        for (int i = 0; i < GAPN; i++) sweep($sformatf("fresh_g%0d", i));
        check("fresh_done", 32'(done_pulses), 32'(exp_done));
        check("fresh_err_total", 32'(err_pulses), 32'd1);
        check("done_with_ready_end", 32'(done_ready_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
